// File: rtl/paddle_encoder_input.sv
// Encoder/button front end: per-channel sync, debounce, quadrature decode and a saturating position.
// Define QUAD_X4_EN for full x4 Gray decode with an err strobe; default is x1 decode on rising A.
module paddle_encoder_input #(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned DEBOUNCE_CNT = 8,
    parameter int unsigned POS_W        = 4,
    parameter int unsigned POS_MAX      = 12,
    parameter int unsigned POS_INIT     = 6
) (
    input  logic                      wb_clk_i,
    input  logic                      reset_n,
    input  logic                      active,
    input  logic                      clear,
    input  logic [CHANNELS-1:0]       enc_a,
    input  logic [CHANNELS-1:0]       enc_b,
    output logic [CHANNELS*POS_W-1:0] pos,
    output logic [CHANNELS-1:0]       step,
    output logic [CHANNELS-1:0]       dir,
`ifdef QUAD_X4_EN
    output logic [CHANNELS-1:0]       sat,
    output logic [CHANNELS-1:0]       err
`else
    output logic [CHANNELS-1:0]       sat
`endif
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [POS_W-1:0] POS_TOP  = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] POS_RST  = POS_W'(POS_INIT);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        // bit 0 carries A, bit 1 carries B through sync and debounce
        logic [1:0]       raw;
        logic [1:0]       s1;
        logic [1:0]       s2;
        logic [1:0]       deb;
        logic [CNT_W-1:0] cnt [2];
        logic             a_prev;
        logic             ev_c;
        logic             up_c;
        logic [POS_W-1:0] pos_q;
        logic             step_q;
        logic             sat_q;
        logic             dir_q;
`ifdef QUAD_X4_EN
        logic             b_prev;
        logic             bad_c;
        logic             err_q;
`endif

        assign raw = {enc_b[ch], enc_a[ch]};

        // Two-flop synchroniser followed by a stable-count debouncer per input
        always_ff @(posedge wb_clk_i or negedge reset_n) begin
            if (!reset_n) begin
                s1     <= '0;
                s2     <= '0;
                deb    <= '0;
                a_prev <= 1'b0;
`ifdef QUAD_X4_EN
                b_prev <= 1'b0;
`endif
                for (int j = 0; j < 2; j++) cnt[j] <= '0;
            end else begin
                s1     <= raw;
                s2     <= s1;
                a_prev <= deb[0];
`ifdef QUAD_X4_EN
                b_prev <= deb[1];
`endif
                for (int j = 0; j < 2; j++) begin
                    if (s2[j] == deb[j]) begin
                        cnt[j] <= '0;
                    end else if (cnt[j] == CNT_LAST) begin
                        deb[j] <= s2[j];
                        cnt[j] <= '0;
                    end else begin
                        cnt[j] <= cnt[j] + CNT_W'(1);
                    end
                end
            end
        end

`ifdef QUAD_X4_EN
        // Gray decode on {prev a, prev b, a, b}; a double-bit jump is an error
        always_comb begin
            ev_c  = 1'b0;
            up_c  = 1'b0;
            bad_c = 1'b0;
            case ({a_prev, b_prev, deb[0], deb[1]})
                4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
                    ev_c = 1'b1;
                    up_c = 1'b1;
                end
                4'b0100, 4'b1101, 4'b1011, 4'b0010: ev_c = 1'b1;
                4'b0011, 4'b1100, 4'b0110, 4'b1001: bad_c = 1'b1;
                default: ;
            endcase
        end
`else
        // Rising A is the only event; held B selects the direction
        always_comb begin
            ev_c = deb[0] & ~a_prev;
            up_c = ~deb[1];
        end
`endif

        // Saturating position counter with single-cycle strobes
        always_ff @(posedge wb_clk_i or negedge reset_n) begin
            if (!reset_n) begin
                pos_q  <= POS_RST;
                step_q <= 1'b0;
                sat_q  <= 1'b0;
                dir_q  <= 1'b0;
`ifdef QUAD_X4_EN
                err_q  <= 1'b0;
`endif
            end else begin
                step_q <= 1'b0;
                sat_q  <= 1'b0;
`ifdef QUAD_X4_EN
                err_q  <= 1'b0;
`endif
                if (clear) begin
                    pos_q <= POS_RST;
                end else if (active && ev_c) begin
                    if (up_c) begin
                        if (pos_q < POS_TOP) begin
                            pos_q  <= pos_q + POS_W'(1);
                            step_q <= 1'b1;
                            dir_q  <= 1'b1;
                        end else begin
                            sat_q  <= 1'b1;
                        end
                    end else begin
                        if (pos_q != '0) begin
                            pos_q  <= pos_q - POS_W'(1);
                            step_q <= 1'b1;
                            dir_q  <= 1'b0;
                        end else begin
                            sat_q  <= 1'b1;
                        end
                    end
`ifdef QUAD_X4_EN
                end else if (active && bad_c) begin
                    err_q <= 1'b1;
`endif
                end
            end
        end

        assign pos[ch*POS_W +: POS_W] = pos_q;
        assign step[ch]               = step_q;
        assign sat[ch]                = sat_q;
        assign dir[ch]                = dir_q;
`ifdef QUAD_X4_EN
        assign err[ch]                = err_q;
`endif
    end

endmodule

// File: tb/tb_paddle_encoder_input.sv
// Directed bench for paddle_encoder_input with a strobe scoreboard; honours QUAD_X4_EN.
module tb_paddle_encoder_input;

    logic       wb_clk_i;
    logic       reset_n;
    logic       active;
    logic       clear;
    logic [1:0] enc_a;
    logic [1:0] enc_b;
    logic [7:0] pos;
    logic [1:0] step;
    logic [1:0] dir;
    logic [1:0] sat;
`ifdef QUAD_X4_EN
    logic [1:0] err;
`endif

    typedef struct {
        int         ch;
        logic       is_sat;
        logic [3:0] pos;
        logic       dir;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   mpos [2];
    logic mdir [2];
    logic [1:0] prev_strobe;

    paddle_encoder_input dut (
        .wb_clk_i (wb_clk_i),
        .reset_n  (reset_n),
        .active   (active),
        .clear    (clear),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .pos      (pos),
        .step     (step),
        .dir      (dir),
`ifdef QUAD_X4_EN
        .sat      (sat),
        .err      (err)
`else
        .sat      (sat)
`endif
    );

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of the saturating counter; queues the strobe the DUT should produce
    task automatic expect_step(input int c, input logic up);
        exp_t x;
        if (!active) return;
        x.is_sat = 1'b0;
        if (up) begin
            if (mpos[c] < 12) begin mpos[c]++; mdir[c] = 1'b1; end
            else x.is_sat = 1'b1;
        end else begin
            if (mpos[c] > 0) begin mpos[c]--; mdir[c] = 1'b0; end
            else x.is_sat = 1'b1;
        end
        x.ch  = c;
        x.pos = 4'(mpos[c]);
        x.dir = mdir[c];
        sb.push_back(x);
    endtask

`ifndef QUAD_X4_EN
    task automatic do_steps(input logic [1:0] mask, input logic [1:0] up);
        @(negedge wb_clk_i);
        for (int c = 0; c < 2; c++) if (mask[c]) enc_b[c] = ~up[c];
        repeat (12) @(negedge wb_clk_i);
        for (int c = 0; c < 2; c++) if (mask[c]) expect_step(c, up[c]);
        for (int c = 0; c < 2; c++) if (mask[c]) enc_a[c] = 1'b1;
        repeat (12) @(negedge wb_clk_i);
        enc_a = enc_a & ~mask;
        repeat (15) @(negedge wb_clk_i);
        chk("sb_pending", sb.size(), 0);
    endtask
`endif

    // Strobe monitor: every step/sat must match the head of the scoreboard
    always @(negedge wb_clk_i) begin
        exp_t e;
        if (!reset_n) begin
            prev_strobe = '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (prev_strobe[c]) chk("strobe_width", 32'(step[c] | sat[c]), 0);
                if (step[c] | sat[c]) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected", 32'({step[c], sat[c]}), 0);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_ch", c, e.ch);
                        chk("sb_step", 32'(step[c]), 32'(!e.is_sat));
                        chk("sb_sat", 32'(sat[c]), 32'(e.is_sat));
                        chk("sb_pos", 32'(pos[c*4 +: 4]), 32'(e.pos));
                        chk("sb_dir", 32'(dir[c]), 32'(e.dir));
                    end
                end
            end
            prev_strobe = step | sat;
        end
    end

    initial begin
        reset_n = 1'b0;
        active  = 1'b1;
        clear   = 1'b0;
        enc_a   = '0;
        enc_b   = '0;
        mpos    = '{6, 6};
        mdir    = '{1'b0, 1'b0};

        // Reset holds everything while inputs toggle
        repeat (10) @(negedge wb_clk_i) begin
            enc_a = ~enc_a;
            enc_b = 2'($urandom);
        end
        enc_a = '0;
        enc_b = '0;
        chk("rst_pos", 32'(pos), 32'h66);
        chk("rst_step", 32'(step), 0);
        chk("rst_sat", 32'(sat), 0);
        chk("rst_dir", 32'(dir), 0);
        @(negedge wb_clk_i);
        reset_n = 1'b1;
        repeat (100) @(negedge wb_clk_i);
        chk("idle_pos", 32'(pos), 32'h66);
        chk("idle_strobes", 32'({step, sat}), 0);

`ifndef QUAD_X4_EN
        // Exact latency: raw edge sampled at edge k lands after edge k+10
        expect_step(0, 1'b1);
        enc_a[0] = 1'b1;
        repeat (10) @(posedge wb_clk_i);
        #1;
        chk("lat_pre_pos", 32'(pos[3:0]), 6);
        chk("lat_pre_step", 32'(step[0]), 0);
        @(posedge wb_clk_i);
        #1;
        chk("lat_pos", 32'(pos[3:0]), 7);
        chk("lat_step", 32'(step[0]), 1);
        chk("lat_dir", 32'(dir[0]), 1);
        chk("lat_ch1_pos", 32'(pos[7:4]), 6);
        chk("lat_ch1_step", 32'(step[1]), 0);
        @(posedge wb_clk_i);
        #1;
        chk("lat_step_off", 32'(step[0]), 0);
        @(negedge wb_clk_i);
        enc_a[0] = 1'b0;
        repeat (20) @(negedge wb_clk_i);

        // Glitch of 7 cycles rejected, 8 cycles accepted
        enc_a[0] = 1'b1;
        repeat (7) @(negedge wb_clk_i);
        enc_a[0] = 1'b0;
        repeat (20) @(negedge wb_clk_i);
        chk("glitch7_pos", 32'(pos[3:0]), 7);
        expect_step(0, 1'b1);
        enc_a[0] = 1'b1;
        repeat (8) @(negedge wb_clk_i);
        enc_a[0] = 1'b0;
        repeat (20) @(negedge wb_clk_i);
        chk("glitch8_pending", sb.size(), 0);
        chk("glitch8_pos", 32'(pos[3:0]), 8);

        // Clear on the very cycle the event lands wins
        enc_a[0] = 1'b1;
        repeat (10) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        clear = 1'b1;
        @(posedge wb_clk_i);
        #1;
        chk("clr_hit_pos", 32'(pos[3:0]), 6);
        chk("clr_hit_step", 32'(step[0]), 0);
        @(negedge wb_clk_i);
        clear    = 1'b0;
        enc_a[0] = 1'b0;
        mpos[0]  = 6;
        repeat (20) @(negedge wb_clk_i);
        chk("clr_after_pos", 32'(pos[3:0]), 6);

        // Inactive: events discarded
        active = 1'b0;
        repeat (3) do_steps(2'b01, 2'b01);
        chk("inact_pos", 32'(pos), 32'h66);
        active = 1'b1;
        do_steps(2'b01, 2'b01);
        chk("react_pos", 32'(pos[3:0]), 7);

        @(negedge wb_clk_i);
        clear = 1'b1;
        @(negedge wb_clk_i);
        clear   = 1'b0;
        mpos[0] = 6;
        chk("clr_pos", 32'(pos[3:0]), 6);

        // Saturation at the top, then all the way down to 0 and below
        repeat (6) do_steps(2'b01, 2'b01);
        chk("top_pos", 32'(pos[3:0]), 12);
        do_steps(2'b01, 2'b01);
        chk("top_sat_pos", 32'(pos[3:0]), 12);
        repeat (12) do_steps(2'b01, 2'b00);
        chk("bot_pos", 32'(pos[3:0]), 0);
        do_steps(2'b01, 2'b00);
        chk("bot_sat_pos", 32'(pos[3:0]), 0);
        chk("bot_dir", 32'(dir[0]), 0);

        // Simultaneous events on both channels
        do_steps(2'b11, 2'b01);
        chk("dual_pos", 32'(pos), 32'h51);

        // Reset mid-debounce aborts the pending step
        @(negedge wb_clk_i);
        enc_a[0] = 1'b1;
        repeat (5) @(negedge wb_clk_i);
        reset_n  = 1'b0;
        enc_a[0] = 1'b0;
        @(negedge wb_clk_i);
        chk("midrst_pos", 32'(pos), 32'h66);
        chk("midrst_dir", 32'(dir), 0);
        mpos = '{6, 6};
        mdir = '{1'b0, 1'b0};
        enc_b = '0;
        @(negedge wb_clk_i);
        reset_n = 1'b1;
        repeat (25) @(negedge wb_clk_i);
        chk("midrst_after_pos", 32'(pos), 32'h66);
`else
        // x4: one full Gray cycle up, then an illegal jump, then one step down
        begin
            logic [1:0] seq [4];
            int errs;
            seq = '{2'b01, 2'b11, 2'b10, 2'b00};
            for (int i = 0; i < 4; i++) begin
                @(negedge wb_clk_i);
                {enc_a[0], enc_b[0]} = seq[i];
                expect_step(0, 1'b1);
                repeat (14) @(negedge wb_clk_i);
            end
            chk("x4_pending", sb.size(), 0);
            chk("x4_pos", 32'(pos[3:0]), 10);
            {enc_a[0], enc_b[0]} = 2'b11;
            errs = 0;
            repeat (20) @(negedge wb_clk_i) if (err[0]) errs++;
            chk("x4_err_count", errs, 1);
            chk("x4_err_pos", 32'(pos[3:0]), 10);
            enc_a[0] = 1'b0;
            expect_step(0, 1'b0);
            repeat (15) @(negedge wb_clk_i);
            chk("x4_down_pending", sb.size(), 0);
            chk("x4_down_pos", 32'(pos[3:0]), 9);
            chk("x4_ch1_err", 32'(err[1]), 0);
        end
`endif

        repeat (5) @(negedge wb_clk_i);
        chk("sb_drain", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
